// File: rtl/tiny16_pkg.sv
`default_nettype none
// ============================================================================
// tiny16_pkg : shared register-map helpers for tiny16 peripherals
// Rev 1.0
// ============================================================================
package tiny16_pkg;

    function automatic int out_base();
        return 0;
    endfunction

    function automatic int in_base(input int n_out);
        return n_out;
    endfunction

    function automatic int status_addr(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    function automatic int mask_addr(input int n_out, input int n_in);
        return n_out + n_in + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync.sv
`default_nettype none
// ============================================================================
// io_sync : 2-flop pin synchronizer plus history stage with change detect
// Rev 1.0
// ============================================================================
module io_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync,
    output logic             change
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stage2;
    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            stage2 <= '0;
            hist   <= '0;
        end else begin
            meta   <= pins;
            stage2 <= meta;
            hist   <= stage2;
        end
    end

    assign sync   = stage2;
    assign change = |(stage2 ^ hist);

endmodule
`default_nettype wire

// File: rtl/io_ports.sv
`default_nettype none
// ============================================================================
// io_ports : bus-mapped output/input pin ports with change-flag interrupt
// Rev 1.0
// ============================================================================
module io_ports
    import tiny16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PORT_W = 8,
    parameter int N_OUT  = 2,
    parameter int N_IN   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    addr_en,
    input  logic                    in_en,
    input  logic                    out_en,
    input  logic [DATA_W-1:0]       in,
    output logic [DATA_W-1:0]       out,
    input  logic [N_IN*PORT_W-1:0]  pins_in,
    output logic [N_OUT*PORT_W-1:0] pins_out,
    output logic                    irq
);

    localparam int OUT_BASE = out_base();
    localparam int IN_BASE  = in_base(N_OUT);
    localparam logic [DATA_W-1:0] STATUS_ADDR = DATA_W'(status_addr(N_OUT, N_IN));
    localparam logic [DATA_W-1:0] MASK_ADDR   = DATA_W'(mask_addr(N_OUT, N_IN));

    logic [DATA_W-1:0]            addr;
    logic [N_OUT-1:0][PORT_W-1:0] out_q;
    logic [N_IN-1:0][PORT_W-1:0]  in_sync;
    logic [N_IN-1:0]              in_change;
    logic [N_IN-1:0]              status;
    logic [N_IN-1:0]              mask;
    logic [N_IN-1:0]              status_clr;
    logic [DATA_W-1:0]            rd_data;

    for (genvar k = 0; k < N_IN; k++) begin : g_in_sync
        io_sync #(.WIDTH(PORT_W)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .pins   (pins_in[k*PORT_W +: PORT_W]),
            .sync   (in_sync[k]),
            .change (in_change[k])
        );
    end

    assign status_clr = (in_en && addr == STATUS_ADDR) ? in[N_IN-1:0] : '0;

    // Writes decode against the address held before this edge, so an
    // address load on the same edge only affects the following access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= '0;
            out_q  <= '0;
            status <= '0;
            mask   <= '0;
            irq    <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (in_en && addr == DATA_W'(OUT_BASE + k)) begin
                    out_q[k] <= in[PORT_W-1:0];
                end
            end
            if (in_en && addr == MASK_ADDR) begin
                mask <= in[N_IN-1:0];
            end
            // A fresh change overrides a simultaneous clear of the same bit.
            status <= (status & ~status_clr) | in_change;
            irq    <= |(status & mask);
            if (addr_en) begin
                addr <= in;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (addr == DATA_W'(OUT_BASE + k)) begin
                rd_data = DATA_W'(out_q[k]);
            end
        end
        for (int k = 0; k < N_IN; k++) begin
            if (addr == DATA_W'(IN_BASE + k)) begin
                rd_data = DATA_W'(in_sync[k]);
            end
        end
        if (addr == STATUS_ADDR) begin
            rd_data = DATA_W'(status);
        end
        if (addr == MASK_ADDR) begin
            rd_data = DATA_W'(mask);
        end
    end

    assign out      = out_en ? rd_data : '0;
    assign pins_out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_io_ports.sv
`default_nettype none
// ============================================================================
// tb_io_ports : randomized and directed checks of io_ports against a model
// Rev 1.0
// ============================================================================
module tb_io_ports;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_en, in_en, out_en;
    logic [15:0] in;
    logic [15:0] out;
    logic [15:0] pins_in;
    logic [15:0] pins_out;
    logic        irq;

    logic        addr_en2, in_en2, out_en2;
    logic [15:0] in2;
    logic [15:0] out2;
    logic [11:0] pins_in2;
    logic [15:0] pins_out2;
    logic        irq2;

    int n_checks = 0;
    int n_fail   = 0;

    io_ports u_dut (
        .clk(clk), .rst(rst), .addr_en(addr_en), .in_en(in_en), .out_en(out_en),
        .in(in), .out(out), .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
    );

    io_ports #(.DATA_W(16), .PORT_W(4), .N_OUT(4), .N_IN(3)) u_dut2 (
        .clk(clk), .rst(rst), .addr_en(addr_en2), .in_en(in_en2), .out_en(out_en2),
        .in(in2), .out(out2), .pins_in(pins_in2), .pins_out(pins_out2), .irq(irq2)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus the full history of pin values
    // seen at each clock edge since reset.
    logic [7:0]  m_out [2];
    logic [1:0]  m_status, m_mask;
    logic        m_irq;
    logic [15:0] m_addr;
    logic [15:0] samp [0:4095];
    int          n_edge;

    function automatic logic [15:0] sample(input int n);
        if (n <= 0) return 16'h0;
        return samp[n];
    endfunction

    function automatic void model_reset();
        m_out[0] = 8'h0; m_out[1] = 8'h0;
        m_status = 2'b0; m_mask = 2'b0; m_irq = 1'b0;
        m_addr = 16'h0; n_edge = 0;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] s;
        s = sample(n_edge - 1);
        case (a)
            16'd0:   return {8'h0, m_out[0]};
            16'd1:   return {8'h0, m_out[1]};
            16'd2:   return {8'h0, s[7:0]};
            16'd3:   return {8'h0, s[15:8]};
            16'd4:   return {14'h0, m_status};
            16'd5:   return {14'h0, m_mask};
            default: return 16'h0;
        endcase
    endfunction

    // A pin value first present at edge n is flagged at edge n+2.
    function automatic void model_edge();
        logic [1:0]  chg, clr;
        logic [15:0] s2, s3;
        if (rst) return;
        n_edge = n_edge + 1;
        samp[n_edge] = pins_in;
        s2 = sample(n_edge - 2);
        s3 = sample(n_edge - 3);
        chg[0] = (s2[7:0]  != s3[7:0]);
        chg[1] = (s2[15:8] != s3[15:8]);
        clr = 2'b0;
        m_irq = |(m_status & m_mask);
        if (in_en) begin
            if (m_addr == 16'd0)      m_out[0] = in[7:0];
            else if (m_addr == 16'd1) m_out[1] = in[7:0];
            else if (m_addr == 16'd4) clr = in[1:0];
            else if (m_addr == 16'd5) m_mask = in[1:0];
        end
        m_status = (m_status & ~clr) | chg;
        if (addr_en) m_addr = in;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_addr(input logic [15:0] a);
        addr_en = 1'b1; in_en = 1'b0; in = a;
        step();
        addr_en = 1'b0;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        set_addr(a);
        in_en = 1'b1; in = d;
        step();
        in_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr_en = 0; in_en = 0; out_en = 0; in = 0; pins_in = 0;
        addr_en2 = 0; in_en2 = 0; out_en2 = 0; in2 = 0; pins_in2 = 0;
        step(); step();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (pins_out !== 16'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: pins_out=%h irq=%b, want 0000 0", pins_out, irq);
        end
        for (int a = 0; a < 8; a++) begin
            set_addr(16'(a));
            out_en = 1'b1; #1;
            n_checks++;
            if (out !== 16'h0) begin
                n_fail++; $display("FAIL reset_read[%0d]: got %h want 0000", a, out);
            end
            out_en = 1'b0; #1;
        end
    endtask

    task automatic test_out_write();
        set_addr(16'h0);
        in_en = 1'b1; in = 16'hABCD;
        step();
        in_en = 1'b0;
        n_checks++;
        if (pins_out[7:0] !== 8'hCD) begin
            n_fail++; $display("FAIL out_write_pins: got %h want cd", pins_out[7:0]);
        end
        out_en = 1'b1; #1;
        n_checks++;
        if (out !== 16'h00CD) begin
            n_fail++; $display("FAIL out_write_read: got %h want 00cd", out);
        end
        out_en = 1'b0;
    endtask

    task automatic test_pin_change();
        write_reg(16'd5, 16'h0002);
        set_addr(16'd3);
        pins_in = 16'h5A00;
        out_en = 1'b1;
        step();
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL in_after_1_edge: got %h want 0000", out);
        end
        step();
        n_checks++;
        if (out !== 16'h005A) begin
            n_fail++; $display("FAIL in_after_2_edges: got %h want 005a", out);
        end
        set_addr(16'd4);
        out_en = 1'b1; #1;
        n_checks++;
        if (out !== 16'h0002 || irq !== 1'b0) begin
            n_fail++; $display("FAIL status_after_3_edges: status=%h irq=%b want 0002 0", out, irq);
        end
        step();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise: got %b want 1", irq);
        end
    endtask

    task automatic test_w1c();
        pins_in = 16'hA500;
        step(); step();
        in_en = 1'b1; in = 16'h0002;
        step();
        n_checks++;
        if (out !== 16'h0002 || irq !== 1'b1) begin
            n_fail++; $display("FAIL w1c_set_wins: status=%h irq=%b want 0002 1", out, irq);
        end
        step();
        in_en = 1'b0;
        n_checks++;
        if (out !== 16'h0000 || irq !== 1'b1) begin
            n_fail++; $display("FAIL w1c_clear: status=%h irq=%b want 0000 1", out, irq);
        end
        step();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_fall: got %b want 0", irq);
        end
        out_en = 1'b0;
    endtask

    task automatic test_ignored_writes();
        write_reg(16'd2, 16'hFFFF);
        write_reg(16'd7, 16'hFFFF);
        n_checks++;
        if (pins_out !== {m_out[1], m_out[0]}) begin
            n_fail++; $display("FAIL ignored_pins_out: got %h want %h", pins_out, {m_out[1], m_out[0]});
        end
        out_en = 1'b1; #1;
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL read_addr7: got %h want 0000", out);
        end
        for (int a = 0; a < 6; a++) begin
            set_addr(16'(a));
            out_en = 1'b1; #1;
            n_checks++;
            if (out !== m_read(16'(a))) begin
                n_fail++; $display("FAIL ignored_read[%0d]: got %h want %h", a, out, m_read(16'(a)));
            end
        end
        out_en = 1'b0;
    endtask

    task automatic test_async_reset();
        write_reg(16'd1, 16'h003C);
        pins_in = 16'h0001;
        write_reg(16'd5, 16'h0003);
        step(); step();
        n_checks++;
        if (pins_out[15:8] !== 8'h3C || irq !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: pins_out=%h irq=%b want 3c.. 1", pins_out, irq);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pins_out !== 16'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: pins_out=%h irq=%b want 0000 0", pins_out, irq);
        end
        pins_in = 16'h0;
        step();
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < 6; a++) begin
            set_addr(16'(a));
            out_en = 1'b1; #1;
            n_checks++;
            if (out !== 16'h0) begin
                n_fail++; $display("FAIL post_reset_read[%0d]: got %h want 0000", a, out);
            end
        end
        out_en = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_out;
        for (int i = 0; i < 1500; i++) begin
            addr_en = ($urandom_range(0, 3) == 0);
            in_en   = ($urandom_range(0, 2) == 0);
            out_en  = $urandom_range(0, 1) == 1;
            in      = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) pins_in = 16'($urandom);
            step();
            exp_out = out_en ? m_read(m_addr) : 16'h0;
            n_checks++;
            if (out !== exp_out) begin
                n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", i, out, exp_out);
            end
            n_checks++;
            if (pins_out !== {m_out[1], m_out[0]}) begin
                n_fail++; $display("FAIL rand_pins_out[%0d]: got %h want %h", i, pins_out, {m_out[1], m_out[0]});
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_fail++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_irq);
            end
        end
        addr_en = 0; in_en = 0; out_en = 0;
    endtask

    task automatic test_params2();
        logic [15:0] v [11];
        logic [15:0] exp;
        pins_in2 = 12'h5A3;
        step(); step(); step(); step();
        for (int a = 0; a < 11; a++) begin
            v[a] = 16'($urandom);
            addr_en2 = 1'b1; in2 = 16'(a);
            step();
            addr_en2 = 1'b0; in_en2 = 1'b1; in2 = v[a];
            step();
            in_en2 = 1'b0;
        end
        n_checks++;
        if (pins_out2 !== {v[3][3:0], v[2][3:0], v[1][3:0], v[0][3:0]}) begin
            n_fail++; $display("FAIL p2_pins_out: got %h want %h", pins_out2,
                               {v[3][3:0], v[2][3:0], v[1][3:0], v[0][3:0]});
        end
        for (int a = 0; a < 11; a++) begin
            if (a < 4)       exp = {12'h0, v[a][3:0]};
            else if (a == 4) exp = 16'h0003;
            else if (a == 5) exp = 16'h000A;
            else if (a == 6) exp = 16'h0005;
            else if (a == 7) exp = {13'h0, 3'b111 & ~v[7][2:0]};
            else if (a == 8) exp = {13'h0, v[8][2:0]};
            else             exp = 16'h0;
            addr_en2 = 1'b1; in2 = 16'(a);
            step();
            addr_en2 = 1'b0; out_en2 = 1'b1; #1;
            n_checks++;
            if (out2 !== exp) begin
                n_fail++; $display("FAIL p2_read[%0d]: got %h want %h", a, out2, exp);
            end
            out_en2 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_pin_change();
        test_w1c();
        test_ignored_writes();
        test_async_reset();
        test_random();
        test_params2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
